// File: rtl/ecg_dsp_pkg.sv
// Shared types and sizing helpers for the ECG moving-average datapath.
package ecg_dsp_pkg;

   localparam int unsigned DATA_W_DEF = 12;
   localparam int unsigned AXIS_W     = 16;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } avg_state_e;

   // Running-sum width: one extra bit per doubling of the window.
   function automatic int unsigned sum_width(input int unsigned data_w,
                                             input int unsigned taps_log2);
      return data_w + taps_log2;
   endfunction

endpackage

// File: rtl/sample_ring_buf.sv
// Circular history of the last 2^TAPS_LOG2 samples; the slot about to be
// overwritten is the oldest sample and is read combinationally.
module sample_ring_buf
   import ecg_dsp_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned TAPS_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] oldest_c
);

   localparam int unsigned DEPTH = 1 << TAPS_LOG2;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic [TAPS_LOG2-1:0] wptr;

   assign oldest_c = mem[wptr];

   // Reset clears every slot so no pre-reset sample can leak into the sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wptr] <= wr_data;
         wptr      <= wptr + TAPS_LOG2'(1);
      end
   end

endmodule

// File: rtl/ecg_moving_avg_axis.sv
// Boxcar moving average over 2^TAPS_LOG2 AXI4-Stream samples.
// Optional macro SAMPLE_EDGE_QUAL_EN: one sample per rising edge of s_axis_tvalid.
module ecg_moving_avg_axis
   import ecg_dsp_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned TAPS_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [AXIS_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [AXIS_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              fill_done
);

   localparam int unsigned SUM_W = sum_width(DATA_W, TAPS_LOG2);

   avg_state_e           state_q, state_d;
   logic [TAPS_LOG2-1:0] fill_cnt_q, fill_cnt_d;
   logic [SUM_W-1:0]     sum_q, sum_c;
   logic [DATA_W-1:0]    x_c, oldest_c;
   logic                 accept_c, load_out_c;
   logic                 unused_c;

   assign x_c      = s_axis_tdata[DATA_W-1:0];
   assign unused_c = ^s_axis_tdata[AXIS_W-1:DATA_W];

   // Ready depends only on the output stage, never on s_axis_tvalid.
   assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;

`ifdef SAMPLE_EDGE_QUAL_EN
   logic       tvalid_d;
   logic [7:0] edge_drop_cnt;

   assign accept_c = s_axis_tvalid & ~tvalid_d & s_axis_tready;

   // Rising edges that meet a stalled output are lost; count them for debug.
   always_ff @(posedge clk) begin
      if (rst) begin
         tvalid_d      <= 1'b0;
         edge_drop_cnt <= '0;
      end else begin
         tvalid_d <= s_axis_tvalid;
         if (s_axis_tvalid && !tvalid_d && !s_axis_tready && edge_drop_cnt != 8'hFF) begin
            edge_drop_cnt <= edge_drop_cnt + 8'd1;
         end
      end
   end
`else
   assign accept_c = s_axis_tvalid & s_axis_tready;
`endif

   // The oldest entry is always part of the sum, so this never wraps.
   assign sum_c = sum_q + SUM_W'(x_c) - SUM_W'(oldest_c);

   sample_ring_buf #(
      .DATA_W    (DATA_W),
      .TAPS_LOG2 (TAPS_LOG2)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept_c),
      .wr_data  (x_c),
      .oldest_c (oldest_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      load_out_c = 1'b0;
      case (state_q)
         FILL: begin
            if (accept_c) begin
               fill_cnt_d = fill_cnt_q + TAPS_LOG2'(1);
               if (fill_cnt_q == '1) begin
                  state_d    = RUN;
                  load_out_c = 1'b1;
               end
            end
         end
         RUN: begin
            load_out_c = accept_c;
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Single output stage: reload on accept, otherwise clear on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q         <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         fill_done     <= 1'b0;
      end else begin
         if (accept_c) begin
            sum_q <= sum_c;
         end
         fill_done <= (state_d == RUN);
         if (load_out_c) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= AXIS_W'(sum_c >> TAPS_LOG2);
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ecg_moving_avg_axis.sv
// Scoreboard bench for ecg_moving_avg_axis: window model in queues, monitor on negedge.
module tb_ecg_moving_avg_axis;

   localparam int NT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        fill_done;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;    // 0 always ready, 1 random, 2 stalled
   int last_out = -1;
   int out_cnt = 0;
   int exp_q[$];
   int win[$];
   int n_acc = 0;
   bit prev_v = 0;
   bit was_rst = 1;
   bit hold_v = 0;
   int hold_d = 0;

   ecg_moving_avg_axis dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .fill_done     (fill_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   end

   // Monitor + reference model: all inputs are stable at the negedge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         win.delete();
         n_acc   = 0;
         prev_v  = 0;
         was_rst = 1;
         hold_v  = 0;
         out_cnt = 0;
      end else begin
         bit acc;
         int s;
         if (was_rst) begin
            chk("rst_tvalid", int'(m_axis_tvalid), 0);
            chk("rst_tdata", int'(m_axis_tdata), 0);
            was_rst = 0;
         end
         chk("fill_done", int'(fill_done), int'(n_acc >= NT));
         chk("s_tready", int'(s_axis_tready), int'(!m_axis_tvalid || m_axis_tready));
         if (hold_v) begin
            chk("hold_valid", int'(m_axis_tvalid), 1);
            chk("hold_data", int'(m_axis_tdata), hold_d);
         end
         hold_v = 0;
         if (m_axis_tvalid) begin
            if (m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out", int'(m_axis_tdata), -1);
               end else begin
                  chk("out_data", int'(m_axis_tdata), exp_q.pop_front());
               end
               last_out = int'(m_axis_tdata);
               out_cnt++;
            end else begin
               hold_v = 1;
               hold_d = int'(m_axis_tdata);
            end
         end
`ifdef SAMPLE_EDGE_QUAL_EN
         acc = s_axis_tvalid && !prev_v && s_axis_tready;
`else
         acc = s_axis_tvalid && s_axis_tready;
`endif
         prev_v = s_axis_tvalid;
         if (acc) begin
            win.push_back(int'(s_axis_tdata & 16'h0FFF));
            if (win.size() > NT) void'(win.pop_front());
            n_acc++;
            if (n_acc >= NT) begin
               s = 0;
               foreach (win[i]) s += win[i];
               exp_q.push_back(s / NT);
            end
         end
      end
   end

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one sample until it is taken (edge mode retries with a gap).
   task automatic send(input logic [15:0] d);
      bit ok = 0;
      int tries = 0;
      while (!ok) begin
         s_axis_tdata  = d;
         s_axis_tvalid = 1'b1;
         @(negedge clk);
         ok = s_axis_tready;
         @(posedge clk);
         #1;
         s_axis_tvalid = 1'b0;
`ifdef SAMPLE_EDGE_QUAL_EN
         if (!ok) idle(1);
`endif
         tries++;
         if (tries > 500) begin
            chk("send_timeout", 0, 1);
            ok = 1;
         end
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   initial begin
      int drain;
      @(posedge clk);
      #1;
      do_reset(3);

      for (int i = 0; i < 7; i++) send(16'd100);
      idle(2);
      chk("no_out_in_fill", out_cnt, 0);
      send(16'd100);
      idle(3);
      chk("first_out", last_out, 100);
      chk("fill_done_set", int'(fill_done), 1);

      send(16'd900);
      idle(3);
      chk("step_900", last_out, 200);
      for (int i = 0; i < 7; i++) send(16'd900);
      idle(3);
      chk("settle_900", last_out, 900);

      for (int i = 0; i < 9; i++) send(16'hF000 | 16'd4095);
      idle(3);
      chk("full_scale", last_out, 4095);

      rdy_mode = 2;
      send(16'd1000);
      fork
         begin
            repeat (10) @(posedge clk);
            rdy_mode = 0;
         end
      join_none
      for (int i = 0; i < 20; i++) send(16'(i * 150));
      idle(3);

      rdy_mode = 1;
      for (int i = 0; i < 200; i++) begin
         send(16'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      rdy_mode = 0;
      idle(4);

      rdy_mode = 2;
      send(16'd7);
      idle(2);
      do_reset(1);
      rdy_mode = 0;
      for (int i = 0; i < 5; i++) send(16'd3000);
      do_reset(1);
      for (int i = 0; i < 8; i++) send(16'd40);
      idle(3);
      chk("post_rst_out", last_out, 40);
      chk("post_rst_cnt", out_cnt, 1);

`ifdef SAMPLE_EDGE_QUAL_EN
      do_reset(2);
      for (int k = 0; k < 8; k++) begin
         s_axis_tdata  = 16'd300;
         s_axis_tvalid = 1'b1;
         repeat (6) begin
            @(posedge clk);
            #1;
         end
         idle(2);
      end
      idle(3);
      chk("edge_cnt", out_cnt, 1);
      chk("edge_out", last_out, 300);
`endif

      drain = 0;
      while (exp_q.size() != 0 && drain < 100) begin
         @(posedge clk);
         drain++;
      end
      chk("drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
